// File: rtl/vc_pop_arbiter_pkg.sv
// Shared types and constants for the VC read-side arbiter
// and the VC/destination FIFOs around it.
package vc_pop_arbiter_pkg;

  localparam int VC_DATA_WIDTH = 6;
  localparam int VC_DEST_BIT   = 4;
  localparam int VC_CNT_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic SRC_VC0 = 1'b0;
  localparam logic SRC_VC1 = 1'b1;

endpackage

// File: rtl/vc_route_demux.sv
// Routes the returned VC word to D0 or D1 by its header bit.
// Output is zero and both enables low when nothing is in flight.
module vc_route_demux
  import vc_pop_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = VC_DATA_WIDTH,
  parameter int DEST_BIT   = VC_DEST_BIT
) (
  input  logic                  inflight,
  input  logic                  src_sel,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  d0_wr_en,
  output logic                  d1_wr_en
);

  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    word     = '0;
    data_out = '0;
    d0_wr_en = 1'b0;
    d1_wr_en = 1'b0;
    if (inflight) begin
      word     = (src_sel == SRC_VC1) ? vc1_data : vc0_data;
      data_out = word;
      d0_wr_en = !word[DEST_BIT];
      d1_wr_en = word[DEST_BIT];
    end
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Read-side arbiter for the VC0/VC1 FIFOs feeding D0/D1.
// Define VC_ARB_RR_EN for round-robin instead of VC0 priority.
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = VC_DATA_WIDTH,
  parameter int DEST_BIT   = VC_DEST_BIT,
  parameter int CNT_WIDTH  = VC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  vc_error,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_rd_en,
  output logic                  vc1_rd_en,
  output logic                  d0_wr_en,
  output logic                  d1_wr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            state,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  d0_count,
  output logic [CNT_WIDTH-1:0]  d1_count
);

  state_t cur_st;
  state_t nxt_st;

  logic inflight;
  logic src_sel;
  logic not_bp;
  logic can_issue;
  logic pop;
  logic push_ok;

  // Destination is unknown until the word returns, so gate on both.
  assign not_bp = !d0_almost_full && !d1_almost_full;

  assign can_issue = ((cur_st == ST_IDLE) || (cur_st == ST_ACTIVE))
                   && !init && !vc_error && not_bp;

`ifdef VC_ARB_RR_EN
  logic last_grant;

  assign vc0_rd_en = can_issue && !vc0_empty
                   && (vc1_empty || (last_grant == SRC_VC1));
  assign vc1_rd_en = can_issue && !vc1_empty
                   && (vc0_empty || (last_grant == SRC_VC0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= SRC_VC1;
    end else if (pop) begin
      last_grant <= !last_grant;
    end
  end
`else
  assign vc0_rd_en = can_issue && !vc0_empty;
  assign vc1_rd_en = can_issue && vc0_empty && !vc1_empty;
`endif

  assign pop = vc0_rd_en || vc1_rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      src_sel  <= SRC_VC0;
    end else begin
      inflight <= pop;
      if (pop) begin
        src_sel <= vc1_rd_en ? SRC_VC1 : SRC_VC0;
      end
    end
  end

  // init drops the word that is still in flight.
  assign push_ok = inflight && !init;

  vc_route_demux #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEST_BIT   (DEST_BIT)
  ) u_demux (
    .inflight (push_ok),
    .src_sel  (src_sel),
    .vc0_data (vc0_data),
    .vc1_data (vc1_data),
    .data_out (data_out),
    .d0_wr_en (d0_wr_en),
    .d1_wr_en (d1_wr_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st <= ST_RESET;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    if (cur_st == ST_RESET) begin
      nxt_st = (vc_error && !init) ? ST_ERROR : ST_INIT;
    end else if (cur_st == ST_ERROR) begin
      nxt_st = ST_ERROR;
    end else if (init) begin
      nxt_st = ST_INIT;
    end else if (vc_error) begin
      nxt_st = ST_ERROR;
    end else begin
      case (cur_st)
        ST_INIT: nxt_st = ST_IDLE;
        ST_IDLE: begin
          if (pop) nxt_st = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!pop && !inflight) nxt_st = ST_IDLE;
        end
        default: nxt_st = cur_st;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_count <= '0;
      d1_count <= '0;
    end else if (init) begin
      d0_count <= '0;
      d1_count <= '0;
    end else begin
      if (d0_wr_en) d0_count <= d0_count + 1'b1;
      if (d1_wr_en) d1_count <= d1_count + 1'b1;
    end
  end

  assign state = cur_st;
  assign idle  = (cur_st == ST_IDLE) && !inflight;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter with simple VC FIFO models.
// Round-robin checks are enabled with VC_ARB_RR_EN.
module tb_vc_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b1;
  logic       vc_error = 1'b0;
  logic       d0_af = 1'b0;
  logic       d1_af = 1'b0;
  logic       vc0_empty;
  logic       vc1_empty;
  logic [5:0] vc0_data = '0;
  logic [5:0] vc1_data = '0;
  logic       vc0_rd_en;
  logic       vc1_rd_en;
  logic       d0_wr_en;
  logic       d1_wr_en;
  logic [5:0] data_out;
  logic [2:0] state;
  logic       idle;
  logic [7:0] d0_count;
  logic [7:0] d1_count;

  int ncmp = 0;
  int nerr = 0;

  logic [5:0] m0 [32];
  logic [5:0] m1 [32];
  int w0 = 0;
  int w1 = 0;
  int r0 = 0;
  int r1 = 0;

  assign vc0_empty = (r0 == w0);
  assign vc1_empty = (r1 == w1);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vc0_rd_en) begin
      vc0_data <= m0[r0];
      r0 <= r0 + 1;
    end
    if (vc1_rd_en) begin
      vc1_data <= m1[r1];
      r1 <= r1 + 1;
    end
  end

  vc_pop_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .vc_error       (vc_error),
    .d0_almost_full (d0_af),
    .d1_almost_full (d1_af),
    .vc0_rd_en      (vc0_rd_en),
    .vc1_rd_en      (vc1_rd_en),
    .d0_wr_en       (d0_wr_en),
    .d1_wr_en       (d1_wr_en),
    .data_out       (data_out),
    .state          (state),
    .idle           (idle),
    .d0_count       (d0_count),
    .d1_count       (d1_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put0(input logic [5:0] x);
    m0[w0] = x;
    w0++;
  endtask

  task automatic put1(input logic [5:0] x);
    m1[w1] = x;
    w1++;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd0"}, 32'(vc0_rd_en), 0);
    chk({tag, "_rd1"}, 32'(vc1_rd_en), 0);
    chk({tag, "_wr0"}, 32'(d0_wr_en), 0);
    chk({tag, "_wr1"}, 32'(d1_wr_en), 0);
  endtask

  // Expected word order for the mixed-VC priority step
`ifdef VC_ARB_RR_EN
  localparam logic [5:0] P2_DATA = 6'h12;
  localparam logic [5:0] P3_DATA = 6'h01;
`else
  localparam logic [5:0] P2_DATA = 6'h01;
  localparam logic [5:0] P3_DATA = 6'h12;
`endif

  initial begin
    step();
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_cnt0", 32'(d0_count), 0);
    chk("rst_cnt1", 32'(d1_count), 0);
    chk_quiet("rst");

    reset = 1'b0;
    step();
    chk("init_state", 32'(state), 1);
    step();
    chk("init_hold", 32'(state), 1);
    init = 1'b0;
    step();
    chk("idle_state", 32'(state), 2);
    chk("idle_flag", 32'(idle), 1);

    put0(6'h10);
    put0(6'h01);
    put1(6'h12);
    #1;
    chk("p0_rd0", 32'(vc0_rd_en), 1);
    chk("p0_rd1", 32'(vc1_rd_en), 0);
    step();
    chk("p1_state", 32'(state), 3);
    chk("p1_data", 32'(data_out), 32'h10);
    chk("p1_wr1", 32'(d1_wr_en), 1);
    chk("p1_wr0", 32'(d0_wr_en), 0);
    step();
    chk("p2_data", 32'(data_out), 32'(P2_DATA));
    chk("p2_wr0", 32'(d0_wr_en), 32'(!P2_DATA[4]));
    chk("p2_wr1", 32'(d1_wr_en), 32'(P2_DATA[4]));
    step();
    chk("p3_data", 32'(data_out), 32'(P3_DATA));
    chk("p3_wr0", 32'(d0_wr_en), 32'(!P3_DATA[4]));
    chk("p3_wr1", 32'(d1_wr_en), 32'(P3_DATA[4]));
    step();
    chk("p4_cnt0", 32'(d0_count), 1);
    chk("p4_cnt1", 32'(d1_count), 2);
    chk("p4_data", 32'(data_out), 0);
    chk("p4_state", 32'(state), 3);
    chk_quiet("p4");
    step();
    chk("p5_state", 32'(state), 2);
    chk("p5_idle", 32'(idle), 1);

    put1(6'h05);
    put1(6'h13);
    #1;
    chk("bp0_rd1", 32'(vc1_rd_en), 1);
    step();
    d1_af = 1'b1;
    #1;
    chk("bp1_rd1", 32'(vc1_rd_en), 0);
    chk("bp1_wr0", 32'(d0_wr_en), 1);
    chk("bp1_data", 32'(data_out), 32'h05);
    step();
    chk_quiet("bp2");
    chk("bp2_cnt0", 32'(d0_count), 2);
    d1_af = 1'b0;
    #1;
    chk("bp3_rd1", 32'(vc1_rd_en), 1);
    step();
    chk("bp4_wr1", 32'(d1_wr_en), 1);
    chk("bp4_data", 32'(data_out), 32'h13);
    step();
    chk("bp5_cnt1", 32'(d1_count), 3);
    step();
    chk("bp6_state", 32'(state), 2);

    put0(6'h03);
    step();
    init = 1'b1;
    #1;
    chk("in0_wr0", 32'(d0_wr_en), 0);
    chk("in0_data", 32'(data_out), 0);
    step();
    chk("in1_state", 32'(state), 1);
    chk("in1_cnt0", 32'(d0_count), 0);
    chk("in1_cnt1", 32'(d1_count), 0);
    chk_quiet("in1");
    init = 1'b0;
    step();
    chk("in2_state", 32'(state), 2);

    put0(6'h11);
    put0(6'h02);
    step();
    chk("er0_state", 32'(state), 3);
    vc_error = 1'b1;
    #1;
    chk("er0_rd0", 32'(vc0_rd_en), 0);
    step();
    vc_error = 1'b0;
    #1;
    chk("er1_state", 32'(state), 4);
    chk_quiet("er1");
    step();
    chk("er2_state", 32'(state), 4);
    chk_quiet("er2");

    init = 1'b1;
    reset = 1'b1;
    #1;
    chk("er3_state", 32'(state), 0);
    step();
    reset = 1'b0;
    step();
    chk("rs0_state", 32'(state), 1);
    init = 1'b0;
    step();
    chk("rs1_state", 32'(state), 2);
    chk("rs1_rd0", 32'(vc0_rd_en), 1);
    step();
    chk("rs2_wr0", 32'(d0_wr_en), 1);
    chk("rs2_data", 32'(data_out), 32'h02);
    reset = 1'b1;
    #1;
    chk("rs3_state", 32'(state), 0);
    chk("rs3_data", 32'(data_out), 0);
    chk("rs3_idle", 32'(idle), 0);
    chk_quiet("rs3");

`ifdef VC_ARB_RR_EN
    init = 1'b1;
    step();
    reset = 1'b0;
    step();
    init = 1'b0;
    step();
    chk("rr_state", 32'(state), 2);
    put0(6'h21);
    put0(6'h22);
    put0(6'h23);
    put1(6'h31);
    put1(6'h32);
    put1(6'h33);
    #1;
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("rr%0d_rd0", g), 32'(vc0_rd_en), 32'(g % 2 == 0));
      chk($sformatf("rr%0d_rd1", g), 32'(vc1_rd_en), 32'(g % 2 == 1));
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
- Read-side controller for the VC0/VC1 virtual-channel FIFOs.
- Arbitrates between the two VCs, pops one word per cycle from the winning FIFO, and routes the returned word to destination FIFO D0 or D1 by a header bit.
- Honours downstream almost-full backpressure.
- Sits between the VC FIFO pair and the D0/D1 destination FIFOs in the transmit path.

Parameters:
- DATA_WIDTH, 6, word width; matches the VC FIFO data width.
- DEST_BIT, 4, index of the data bit selecting the destination: 0 -> D0, 1 -> D1.
- CNT_WIDTH, 8, width of the forwarded-word counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- init  in  1  synchronous; while high, hold in INIT and issue no pops.
- vc0_empty  in  1  VC0 FIFO empty flag.
- vc1_empty  in  1  VC1 FIFO empty flag.
- vc0_data  in  DATA_WIDTH  VC0 FIFO registered read data; valid the cycle after vc0_rd_en.
- vc1_data  in  DATA_WIDTH  VC1 FIFO registered read data; valid the cycle after vc1_rd_en.
- vc_error  in  1  OR of the VC FIFO error flags.
- d0_almost_full  in  1  D0 FIFO almost-full flag.
- d1_almost_full  in  1  D1 FIFO almost-full flag.
- vc0_rd_en  out  1  pop VC0.
- vc1_rd_en  out  1  pop VC1.
- d0_wr_en  out  1  push data_out into D0.
- d1_wr_en  out  1  push data_out into D1.
- data_out  out  DATA_WIDTH  word being pushed; 0 when no push.
- state  out  3  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- idle  out  1  high in IDLE with no word in flight.
- d0_count  out  CNT_WIDTH  words pushed to D0; wraps.
- d1_count  out  CNT_WIDTH  words pushed to D1; wraps.

Behaviour:
- Reset values: every output is 0; state=RESET.
- FSM transitions:
  - RESET -> INIT on the first clock after reset deasserts.
  - INIT -> IDLE when init=0.
  - IDLE -> ACTIVE when any pop is issued.
  - ACTIVE -> IDLE when a cycle issues no pop and no word is in flight.
  - Any state other than RESET -> INIT whenever init=1. This discards the in-flight flag and issues no write for it, and clears the counters.
  - Any state -> ERROR when vc_error=1. ERROR is sticky until reset; no pops or pushes occur in it.
- Issue condition, evaluated combinationally in IDLE/ACTIVE: not_bp = !d0_almost_full && !d1_almost_full. Both flags are checked because the destination is unknown until the data returns.
- Arbitration is strict priority:
  - vc0_rd_en = not_bp && !vc0_empty.
  - vc1_rd_en = not_bp && vc0_empty && !vc1_empty.
  - Never both high in one cycle.
- Pipeline:
  - A pop at cycle N registers src_sel and inflight=1.
  - At cycle N+1 the word from the selected VC is driven on data_out.
  - The matching d*_wr_en is asserted combinationally from inflight and data[DEST_BIT].
  - Pop-to-push latency is 1 cycle; throughput is 1 word/cycle.
- Pushes occur even if almost_full rose during the in-flight cycle. The almost-full threshold guarantees at least one slot of headroom.
- data_out = 0 and both wr_en = 0 when inflight=0.
- Counters increment on the corresponding wr_en and wrap 2^CNT_WIDTH-1 -> 0.
- Simultaneous events: reset dominates init; init dominates vc_error; vc_error dominates issue.

Optional Feature:
- Macro VC_ARB_RR_EN.
- Defined: round-robin between VC0 and VC1. A last_grant register flips on every grant. When both VCs are non-empty, the VC not granted last wins. A single non-empty VC always wins. last_grant resets to VC1, so VC0 wins first.
- Undefined: strict VC0 priority as above.

Decomposition:
- Shared package holds:
  - state encodings ST_RESET..ST_ERROR;
  - SRC_VC0=0 and SRC_VC1=1;
  - default DATA_WIDTH and DEST_BIT constants, shared with the VC FIFO and destination FIFOs.
- One natural sub-module, vc_route_demux: combinational mapping of inflight, src_sel, vc0_data, vc1_data and DEST_BIT to data_out, d0_wr_en and d1_wr_en.
- Arbiter, FSM and counters stay in the top module.

Test Plan:
- Reset/init: assert reset mid-traffic -> all outputs 0 immediately, state=0. Release reset with init=1 -> state=1. Drop init -> state=2, idle=1.
- Priority: VC0 holds 6'h10 and 6'h01, VC1 holds 6'h12, no backpressure -> pushes in order 6'h10 to D1, 6'h01 to D0, 6'h12 to D1, each 1 cycle after its pop. d0_count=1, d1_count=2.
- Backpressure: raise d1_almost_full while VC1 is non-empty -> no rd_en next cycle. The in-flight word is still pushed. Popping resumes the cycle after the flag drops.
- Error: pulse vc_error during ACTIVE -> state=4, no rd_en/wr_en afterwards, even after vc_error drops, until reset.
- Init mid-flight: assert init in the cycle after a pop -> no wr_en, counters cleared, state=1.
- VC_ARB_RR_EN: both VCs hold 3 words each -> grants alternate VC0, VC1, VC0, VC1, VC0, VC1.
